mul_final_cpa: RTL

Final reduction and carry-propagate stage of the pipelined Booth/CSA multiplier, directly downstream of the second-level 4:2 compressor stage. It takes four sum/carry pairs, compresses them to one pair, and resolves the 2·DataWidth-bit product with a carry-propagate adder split across two cycles. It returns the low or high product half to EX with a valid/ready handshake, and honours flush.

---
 rtl/mul_final_cpa_if.sv | 37 +++
 rtl/mul_final_cpa.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mul_final_cpa_if.sv
//------------------------------------------------------------------------------
// Module   : mul_final_cpa_if
// Brief    : Operand/result bundle between the 4:2 compressor stage, the
//            final CPA stage and EX.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mul_final_cpa_if #(
  parameter int DATA_WIDTH = 64
);
  localparam int c_prod_w = 2 * DATA_WIDTH;

  logic                           valid_in;
  logic                           in_ready;
  logic [1:0]                     op_sel;
  logic                           flush;
  logic [3:0][c_prod_w-1:0]       sum_pp;
  logic [3:0][c_prod_w-1:0]       carry_pp;
  logic [DATA_WIDTH-1:0]          result;
  logic                           result_valid;
  logic                           result_ready;

  // Upstream/EX side
  modport master (
    output valid_in, op_sel, flush, sum_pp, carry_pp, result_ready,
    input  in_ready, result, result_valid
  );

  // Final CPA stage side
  modport slave (
    input  valid_in, op_sel, flush, sum_pp, carry_pp, result_ready,
    output in_ready, result, result_valid
  );
endinterface

`default_nettype wire

// File: rtl/mul_final_cpa.sv
//------------------------------------------------------------------------------
// Module   : mul_final_cpa
// Brief    : Final 8:2 reduction plus two-cycle split carry-propagate adder of
//            the Booth/CSA multiplier; returns the low or high product half.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mul_final_cpa #(
  parameter int DATA_WIDTH = 64
) (
  input  wire logic       clk,
  input  wire logic       rst,
  mul_final_cpa_if.slave  bus
);

  localparam int c_prod_w = 2 * DATA_WIDTH;
  localparam int c_half_w = DATA_WIDTH;

  // 3:2 carry-save step; carry is pre-shifted with the MSB dropped so the
  // pair stays congruent to a+b+c modulo 2^c_prod_w. Returns {carry, sum}.
  function automatic logic [2*c_prod_w-1:0] csa3(
    input logic [c_prod_w-1:0] a,
    input logic [c_prod_w-1:0] b,
    input logic [c_prod_w-1:0] c
  );
    logic [c_prod_w-1:0] s;
    logic [c_prod_w-1:0] cy;
    s  = a ^ b ^ c;
    cy = ((a & b) | (a & c) | (b & c)) << 1;
    return {cy, s};
  endfunction

  // 4:2 compressor built from two chained 3:2 steps. Returns {carry, sum}.
  function automatic logic [2*c_prod_w-1:0] comp42(
    input logic [c_prod_w-1:0] a,
    input logic [c_prod_w-1:0] b,
    input logic [c_prod_w-1:0] c,
    input logic [c_prod_w-1:0] d
  );
    logic [2*c_prod_w-1:0] t;
    t = csa3(a, b, c);
    return csa3(t[c_prod_w-1:0], t[2*c_prod_w-1:c_prod_w], d);
  endfunction

  // Handshake
  logic w_stall;

  // Reduction tree
  logic [c_prod_w-1:0] w_l1_sum   [2];
  logic [c_prod_w-1:0] w_l1_carry [2];
  logic [c_prod_w-1:0] w_l2_sum;
  logic [c_prod_w-1:0] w_l2_carry;

  // S1 registers
  logic                r_s1_valid;
  logic [1:0]          r_s1_op;
  logic [c_prod_w-1:0] r_s1_sum;
  logic [c_prod_w-1:0] r_s1_carry;

  // S2 registers
  logic                r_s2_valid;
  logic [1:0]          r_s2_op;
  logic [c_half_w-1:0] r_s2_lo;
  logic                r_s2_cout;
  logic [c_half_w-1:0] r_s2_hi_sum;
  logic [c_half_w-1:0] r_s2_hi_carry;

  // S3 registers
  logic                r_result_valid;
  logic [c_half_w-1:0] r_result;

  // CPA halves
  logic [c_half_w:0]   w_lo_add;
  logic [c_half_w-1:0] w_hi_add;
  logic [c_half_w-1:0] w_result_next;

  assign w_stall      = r_result_valid & ~bus.result_ready;
  assign bus.in_ready = ~w_stall;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_l1
      assign {w_l1_carry[g], w_l1_sum[g]} = comp42(bus.sum_pp[2*g],   bus.carry_pp[2*g],
                                                   bus.sum_pp[2*g+1], bus.carry_pp[2*g+1]);
    end
  endgenerate

  assign {w_l2_carry, w_l2_sum} = comp42(w_l1_sum[0], w_l1_carry[0],
                                         w_l1_sum[1], w_l1_carry[1]);

  assign w_lo_add = {1'b0, r_s1_sum[c_half_w-1:0]} + {1'b0, r_s1_carry[c_half_w-1:0]};

  assign w_hi_add = r_s2_hi_sum + r_s2_hi_carry + {{(c_half_w-1){1'b0}}, r_s2_cout};

  // MUL returns the low half; every high-half variant is already signed upstream
  assign w_result_next = (r_s2_op == 2'b00) ? r_s2_lo : w_hi_add;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid     <= 1'b0;
      r_s1_op        <= '0;
      r_s1_sum       <= '0;
      r_s1_carry     <= '0;
      r_s2_valid     <= 1'b0;
      r_s2_op        <= '0;
      r_s2_lo        <= '0;
      r_s2_cout      <= 1'b0;
      r_s2_hi_sum    <= '0;
      r_s2_hi_carry  <= '0;
      r_result_valid <= 1'b0;
      r_result       <= '0;
    end else if (bus.flush) begin
      // Flush wins over stall and drops any operand presented this cycle
      r_s1_valid     <= 1'b0;
      r_s2_valid     <= 1'b0;
      r_result_valid <= 1'b0;
      r_result       <= '0;
    end else if (!w_stall) begin
      r_s1_valid     <= bus.valid_in;
      r_s1_op        <= bus.op_sel;
      r_s1_sum       <= w_l2_sum;
      r_s1_carry     <= w_l2_carry;

      r_s2_valid     <= r_s1_valid;
      r_s2_op        <= r_s1_op;
      r_s2_lo        <= w_lo_add[c_half_w-1:0];
      r_s2_cout      <= w_lo_add[c_half_w];
      r_s2_hi_sum    <= r_s1_sum[c_prod_w-1:c_half_w];
      r_s2_hi_carry  <= r_s1_carry[c_prod_w-1:c_half_w];

      r_result_valid <= r_s2_valid;
      r_result       <= w_result_next;
    end
  end

  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;

endmodule

`default_nettype wire
